// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divisor helper.
package uart_pkg;

  localparam int   UART_DATA_W     = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_e;

  function automatic int calc_bps_cnt(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running bit-period divider with synchronous clear.
module uart_baud_gen #(
  parameter int BPS_CNT = 1250
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  output logic bit_end_o,
  output logic bit_pre_end_o
);

  localparam int CNT_W = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BPS_CNT - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Pre-end lets the owner register a pulse that lands on the last clock of a bit.
  assign bit_end_o     = (cnt_q == CNT_LAST);
  assign bit_pre_end_o = (cnt_q == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: valid/ready byte in, framed serial line out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [UART_DATA_W-1:0] tx_data_in,
  input  logic                   tx_data_valid,
  output logic                   tx_ready,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   rs232_tx
);

  localparam int   BPS_CNT   = calc_bps_cnt(CLK_FREQ, BAUD);
  localparam logic PAR_ODD   = (PARITY_ODD != 0);
  localparam logic LAST_STOP = (STOP_BITS == 2);

  if (BPS_CNT < 2) begin : g_bps_check
    $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_e            state_q, state_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   parity_q, parity_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic accept;
  logic bit_end;
  logic bit_pre_end;

  assign accept = tx_data_valid && ready_q;

  uart_baud_gen #(
    .BPS_CNT(BPS_CNT)
  ) u_baud_gen (
    .clk_i        (clk_in),
    .rst_n_i      (rst_n_in),
    .clr_i        (accept),
    .bit_end_o    (bit_end),
    .bit_pre_end_o(bit_pre_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    parity_d   = parity_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = S_START;
          shift_d    = tx_data_in;
          parity_d   = (^tx_data_in) ^ PAR_ODD;
          bit_idx_d  = '0;
          stop_idx_d = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q == LAST_STOP) begin
            state_d = S_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level follows the state being entered so rs232_tx changes on the bit boundary itself.
  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_d)
      S_IDLE:   tx_d = UART_IDLE_LEVEL;
      S_START:  tx_d = ~UART_IDLE_LEVEL;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = UART_IDLE_LEVEL;
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_q == S_STOP) && (stop_idx_q == LAST_STOP) && bit_pre_end;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign rs232_tx = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx in four frame configurations at BPS_CNT=12.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic [3:0] valid;
  wire  [3:0] rs;
  wire  [3:0] rdy;
  wire  [3:0] bsy;
  wire  [3:0] dn;

  int errors = 0;
  int checks = 0;

  int cfg_pe [4] = '{0, 1, 1, 0};
  int cfg_po [4] = '{0, 0, 1, 0};
  int cfg_sb [4] = '{1, 1, 1, 2};

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(12_000_000), .BAUD(1_000_000)) u_8n1 (
    .clk_in(clk), .rst_n_in(rst_n), .tx_data_in(tx_data), .tx_data_valid(valid[0]),
    .tx_ready(rdy[0]), .tx_busy(bsy[0]), .tx_done(dn[0]), .rs232_tx(rs[0]));
  uart_tx #(.CLK_FREQ(12_000_000), .BAUD(1_000_000), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk_in(clk), .rst_n_in(rst_n), .tx_data_in(tx_data), .tx_data_valid(valid[1]),
    .tx_ready(rdy[1]), .tx_busy(bsy[1]), .tx_done(dn[1]), .rs232_tx(rs[1]));
  uart_tx #(.CLK_FREQ(12_000_000), .BAUD(1_000_000), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk_in(clk), .rst_n_in(rst_n), .tx_data_in(tx_data), .tx_data_valid(valid[2]),
    .tx_ready(rdy[2]), .tx_busy(bsy[2]), .tx_done(dn[2]), .rs232_tx(rs[2]));
  uart_tx #(.CLK_FREQ(12_000_000), .BAUD(1_000_000), .STOP_BITS(2)) u_s2 (
    .clk_in(clk), .rst_n_in(rst_n), .tx_data_in(tx_data), .tx_data_valid(valid[3]),
    .tx_ready(rdy[3]), .tx_busy(bsy[3]), .tx_done(dn[3]), .rs232_tx(rs[3]));

  function automatic int frame_len(input int i);
    return (9 + cfg_pe[i] + cfg_sb[i]) * 12;
  endfunction

  // Cycle c=1 is the first clock after the accepting edge.
  function automatic logic exp_line(input int i, input int c, input logic [7:0] d);
    int b;
    b = (c - 1) / 12;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (cfg_pe[i] != 0 && b == 9) return (^d) ^ (cfg_po[i] != 0);
    return 1'b1;
  endfunction

  task automatic do_accept(input int i, input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    valid[i] = 1'b1;
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic run_frame(input int i, input logic [7:0] d, input int inj_cyc,
                           output int bad, output int done_cyc, output int done_cnt,
                           output logic rdy1, output logic bsy1, output logic rdy_end,
                           output logic [11:0] mid);
    int f;
    f = frame_len(i);
    bad = 0; done_cyc = 0; done_cnt = 0; mid = '0;
    rdy1 = 1'bx; bsy1 = 1'bx; rdy_end = 1'bx;
    do_accept(i, d);
    for (int c = 1; c <= f + 1; c++) begin
      @(negedge clk);
      if (c == inj_cyc) begin
        tx_data  = 8'h3C;
        valid[i] = 1'b1;
      end else if (c == inj_cyc + 1) begin
        valid[i] = 1'b0;
      end
      if (c <= f) begin
        if (rs[i] !== exp_line(i, c, d)) bad++;
        if ((c - 1) % 12 == 6) mid[(c-1)/12] = rs[i];
      end
      if (dn[i] === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (c == 1) begin
        rdy1 = rdy[i];
        bsy1 = bsy[i];
      end
      if (c == f + 1) rdy_end = rdy[i];
    end
    valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = '0; tx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (rs !== 4'hF) begin errors++; $display("FAIL reset_line: got %b want 1111", rs); end
    checks++; if (rdy !== 4'hF) begin errors++; $display("FAIL reset_ready: got %b want 1111", rdy); end
    checks++; if (bsy !== 4'h0) begin errors++; $display("FAIL reset_busy: got %b want 0000", bsy); end
    checks++; if (dn !== 4'h0) begin errors++; $display("FAIL reset_done: got %b want 0000", dn); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rdy[0] !== 1'b1 || rs[0] !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset: ready=%b line=%b want 1 1", rdy[0], rs[0]);
    end
  endtask

  task automatic test_8n1();
    int bad, dc, dcnt; logic r1, b1, re; logic [11:0] mid;
    run_frame(0, 8'h55, 0, bad, dc, dcnt, r1, b1, re, mid);
    checks++; if (bad != 0) begin errors++; $display("FAIL 8n1_line: %0d bad cycles want 0", bad); end
    checks++; if (mid[8:1] !== 8'h55) begin errors++; $display("FAIL 8n1_bits: got %h want 55", mid[8:1]); end
    checks++; if (mid[0] !== 1'b0 || mid[9] !== 1'b1) begin
      errors++; $display("FAIL 8n1_start_stop: start=%b stop=%b want 0 1", mid[0], mid[9]);
    end
    checks++; if (dc != 120) begin errors++; $display("FAIL 8n1_done_cycle: got %0d want 120", dc); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL 8n1_done_count: got %0d want 1", dcnt); end
    checks++; if (r1 !== 1'b0 || b1 !== 1'b1) begin
      errors++; $display("FAIL 8n1_accept_flags: ready=%b busy=%b want 0 1", r1, b1);
    end
    checks++; if (re !== 1'b1) begin errors++; $display("FAIL 8n1_ready_after: got %b want 1", re); end
  endtask

  task automatic test_parity();
    int bad, dc, dcnt; logic r1, b1, re; logic [11:0] mid;
    run_frame(1, 8'hA5, 0, bad, dc, dcnt, r1, b1, re, mid);
    checks++; if (bad != 0) begin errors++; $display("FAIL even_line: %0d bad cycles want 0", bad); end
    checks++; if (mid[8:1] !== 8'hA5) begin errors++; $display("FAIL even_bits: got %h want a5", mid[8:1]); end
    checks++; if (mid[9] !== 1'b0) begin errors++; $display("FAIL even_parity: got %b want 0", mid[9]); end
    checks++; if (dc != 132) begin errors++; $display("FAIL even_done_cycle: got %0d want 132", dc); end
    run_frame(2, 8'hA5, 0, bad, dc, dcnt, r1, b1, re, mid);
    checks++; if (bad != 0) begin errors++; $display("FAIL odd_line: %0d bad cycles want 0", bad); end
    checks++; if (mid[9] !== 1'b1) begin errors++; $display("FAIL odd_parity: got %b want 1", mid[9]); end
    checks++; if (dc != 132 || dcnt != 1) begin
      errors++; $display("FAIL odd_done: cycle=%0d count=%0d want 132 1", dc, dcnt);
    end
  endtask

  task automatic test_back_to_back();
    int c2, done2; logic prev, gap, d0;
    c2 = 0; done2 = 0; prev = 1'b0; gap = 1'bx; d0 = 1'bx;
    @(negedge clk);
    tx_data  = 8'h00;
    valid[3] = 1'b1;
    @(posedge clk);
    #1;
    tx_data = 8'hFF;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (rs[3] !== 1'b0) begin errors++; $display("FAIL b2b_first_start: got %b want 0", rs[3]); end
      end
      if (c == 133) gap = rs[3];
      if (c > 1 && prev === 1'b1 && rs[3] === 1'b0 && c2 == 0) begin
        c2 = c;
        valid[3] = 1'b0;
      end
      if (c2 != 0 && c == c2 + 17) d0 = rs[3];
      if (c2 != 0 && dn[3] === 1'b1 && done2 == 0) done2 = c;
      prev = rs[3];
      if (c2 != 0 && c >= c2 + 160) break;
    end
    valid[3] = 1'b0;
    checks++; if (c2 - 1 != 133) begin errors++; $display("FAIL b2b_spacing: got %0d want 133", c2 - 1); end
    checks++; if (gap !== 1'b1) begin errors++; $display("FAIL b2b_gap_line: got %b want 1", gap); end
    checks++; if (d0 !== 1'b1) begin errors++; $display("FAIL b2b_second_d0: got %b want 1", d0); end
    checks++; if (done2 != c2 + 131) begin errors++; $display("FAIL b2b_second_done: got %0d want %0d", done2, c2 + 131); end
    checks++; if (rdy[3] !== 1'b1 || rs[3] !== 1'b1) begin
      errors++; $display("FAIL b2b_no_third: ready=%b line=%b want 1 1", rdy[3], rs[3]);
    end
  endtask

  task automatic test_ignore();
    int bad, dc, dcnt, extra; logic r1, b1, re; logic [11:0] mid;
    run_frame(0, 8'h96, 40, bad, dc, dcnt, r1, b1, re, mid);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rs[0] !== 1'b1 || bsy[0] !== 1'b0) extra++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ignore_line: %0d bad cycles want 0", bad); end
    checks++; if (mid[8:1] !== 8'h96) begin errors++; $display("FAIL ignore_bits: got %h want 96", mid[8:1]); end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dcnt); end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_extra_frame: %0d busy cycles want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int bad, dc, dcnt, spurious; logic r1, b1, re; logic [11:0] mid;
    spurious = 0;
    do_accept(0, 8'h0F);
    repeat (40) @(negedge clk);
    checks++; if (bsy[0] !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", bsy[0]); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rs[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_async: line=%b ready=%b busy=%b want 1 1 0", rs[0], rdy[0], bsy[0]);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (dn[0] !== 1'b0) spurious++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 130; c++) begin
      @(negedge clk);
      if (dn[0] !== 1'b0 || rs[0] !== 1'b1) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rstmid_no_done: %0d bad cycles want 0", spurious); end
    run_frame(0, 8'h81, 0, bad, dc, dcnt, r1, b1, re, mid);
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_next_line: %0d bad cycles want 0", bad); end
    checks++; if (mid[8:1] !== 8'h81) begin errors++; $display("FAIL rstmid_next_bits: got %h want 81", mid[8:1]); end
    checks++; if (dc != 120) begin errors++; $display("FAIL rstmid_next_done: got %0d want 120", dc); end
  endtask

  logic       rx_en = 1'b0;
  int         frame_err = 0;
  logic [7:0] rx_q [$];

  always begin : rx_model
    logic [7:0] rx_byte;
    @(negedge clk);
    if (rx_en && rs[0] === 1'b0) begin
      repeat (5) @(negedge clk);
      if (rs[0] !== 1'b0) frame_err++;
      for (int b = 0; b < 8; b++) begin
        repeat (12) @(negedge clk);
        rx_byte[b] = rs[0];
      end
      repeat (12) @(negedge clk);
      if (rs[0] !== 1'b1) frame_err++;
      rx_q.push_back(rx_byte);
    end
  end

  task automatic test_loopback();
    logic [7:0] sent [$];
    logic [7:0] d;
    int timeouts, t;
    timeouts = 0;
    rx_en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      d = 8'($urandom_range(0, 255));
      sent.push_back(d);
      do_accept(0, d);
      t = 0;
      while (dn[0] !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) timeouts++;
    end
    repeat (20) @(negedge clk);
    rx_en = 1'b0;
    checks++; if (timeouts != 0) begin errors++; $display("FAIL loop_timeouts: got %0d want 0", timeouts); end
    checks++; if (frame_err != 0) begin errors++; $display("FAIL loop_framing: got %0d want 0", frame_err); end
    checks++; if (rx_q.size() != 256) begin errors++; $display("FAIL loop_count: got %0d want 256", rx_q.size()); end
    for (int k = 0; k < 256 && k < rx_q.size(); k++) begin
      checks++;
      if (rx_q[k] !== sent[k]) begin
        errors++; $display("FAIL loop_byte_%0d: got %h want %h", k, rx_q[k], sent[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
